// File: rtl/float2int_if.sv
// float2int_if: code-in / integer-out valid-ready handshake bundle for float2int_serial.
interface float2int_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  x;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] y;
    modport master (output in_valid, x, out_ready, input in_ready, out_valid, y);
    modport slave (input in_valid, x, out_ready, output in_ready, out_valid, y);
endinterface

// File: rtl/float2int_serial.sv
// float2int_serial: decodes a 3-bit-exp/4-bit-mant code into an 11-bit integer with a bit-serial shifter.
module float2int_serial (
    input  logic           clk,
    input  logic           rst,
    float2int_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t      r_state;
    state_t      w_next;
    logic [10:0] r_acc;
    logic [2:0]  r_cnt;
    logic [2:0]  w_exp;
    logic [3:0]  w_mant;
    logic [2:0]  w_load_cnt;
    logic        w_accept;
    assign w_exp      = bus.x[6:4];
    assign w_mant     = bus.x[3:0];
    assign w_load_cnt = (w_exp == 3'd0) ? 3'd0 : w_exp - 3'd1;
    assign w_accept   = bus.in_valid && bus.in_ready;
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = w_accept ? ((w_load_cnt != 3'd0) ? SHIFT : DONE) :
                 (r_state == SHIFT) ? ((r_cnt == 3'd1) ? DONE : SHIFT) :
                 (r_state == DONE && !bus.out_ready) ? DONE : IDLE;
    end
    always_comb begin
        bus.in_ready  = (r_state == IDLE) || (r_state == DONE && bus.out_ready);
        bus.out_valid = (r_state == DONE);
        bus.y         = r_acc;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= {6'b0, w_exp != 3'd0, w_mant};
            r_cnt <= w_load_cnt;
        end else if (r_state == SHIFT) begin
            r_acc <= {r_acc[9:0], 1'b0};
            r_cnt <= r_cnt - 3'd1;
        end
    end
endmodule

// File: doc/float2int_serial.md
# float2int_serial

Sequential decoder for the 7-bit compact float code that the integer-to-float encoder produces: 3-bit exponent, 4-bit mantissa, expanded back to an exact 11-bit unsigned integer. It takes one code per valid/ready handshake and rebuilds the integer with a bit-serial left shifter, one position per clock. It sits on the read side of the compressed-value path. Paired with the encoder it forms a round-trip pair, used for equivalence checks in the benchmark flow.

## Interface
Parameters: none. Widths are fixed by the code format.

Ports:
- clk  in  1  — single clock; all state changes on the rising edge
- rst  in  1  — reset, synchronous, active-high
- in_valid  in  1  — input code x is valid this cycle
- in_ready  out  1  — block can accept a code this cycle
- x  in  7  — x[6:4] = exp, x[3:0] = mant
- out_valid  out  1  — y holds a finished result
- out_ready  in  1  — consumer accepts y this cycle
- y  out  11  — decoded unsigned integer

## Operation
- Decode rule:
  - exp == 0: value = mant (0..15).
  - exp ≥ 1: value = {1, mant} << (exp−1) (16..1984).
  - The result always fits 11 bits. y[10:0] is exact and zero-extended. There is no rounding and no saturation.
- State machine: IDLE, SHIFT, DONE.
- Accept: an input is accepted on an edge where in_valid && in_ready. On accept:
  - acc is loaded with {6'b0, 1, mant} when exp ≥ 1, else {7'b0, mant}.
  - cnt (3 bits) is loaded with max(exp−1, 0).
  - Next state is SHIFT if the loaded cnt > 0, else DONE.
- SHIFT, each cycle:
  - acc <= acc << 1 (bit shifted out of bit 10 is always 0).
  - cnt <= cnt − 1.
  - When cnt == 1 in this cycle, next state is DONE.
- DONE:
  - out_valid = 1 and y = acc.
  - On out_ready, the result is consumed.
  - If a new input is accepted in the same cycle, the next state is chosen by the accept rule. Otherwise the next state is IDLE.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
  - This is a combinational path from out_ready, so back-to-back codes stream without a bubble.
  - in_ready = 0 throughout SHIFT.
- Backpressure: in DONE with out_ready = 0, y and out_valid hold unchanged indefinitely and no input is accepted.
- in_valid while in_ready = 0 is ignored. The producer must hold x until the accept edge.
- x is sampled only on the accept edge. x changes at any other time have no effect.

## Timing
- Reset values (rst high at an edge): state = IDLE, acc = 0, cnt = 0, out_valid = 0, y = 0, in_ready = 1.
  - Reset takes effect at that edge and overrides any handshake in the same cycle.
- Reset mid-operation (SHIFT or DONE): the result is discarded and not presented. The next cycle behaves as IDLE.
- Latency: out_valid rises 1 + max(exp−1, 0) cycles after the accept edge.
  - Range is 1 (exp = 0 or exp = 1) to 7 (exp = 7).
- Throughput:
  - One result per 1 + max(exp−1, 0) cycles when out_ready is held high.
  - exp ≤ 1 codes sustain one result per cycle.
- out_valid and y are registered. in_ready is combinational from state and out_ready only; it does not depend on in_valid.
- Result values:
  - y is stable and correct only while out_valid = 1.
  - While out_valid = 0, y shows acc, which may be a partial shift.

## Test plan
- Reset then x = 7'h00 accepted, out_ready = 1 → out_valid one cycle later with y = 0; in_ready = 1 throughout.
- x = 7'h1F (exp 1, mant 15) → y = 31 after 1 cycle. x = 7'h25 (exp 2, mant 5) → y = 42 after 2 cycles, with in_ready = 0 for 1 cycle.
- x = 7'h7F → y = 1984 (11'h7C0) after 7 cycles. x = 7'h70 → y = 1024. in_ready is low during all SHIFT cycles.
- Backpressure: decode 7'h3A (→ 104), hold out_ready = 0 for 5 cycles → y = 104 and out_valid stay constant. Raise out_ready with in_valid and x = 7'h05 → 7'h05 is accepted in that same cycle and y = 5 appears on the next cycle.
- Reset mid-shift: accept 7'h7F, assert rst at cycle 3 → out_valid stays 0, y = 0, in_ready = 1 after reset. A following 7'h11 decodes to y = 17.
- Exhaustive round trip: all 128 codes with random in_valid/out_ready gaps.
  - Each y matches the decode rule and results arrive in order.
  - Feeding y into the int2float encoder returns the original code for all codes with exp ≥ 1 or mant < 16.
